// File: rtl/mipi_csi2_des_pkg.sv
// Shared definitions for the CSI-2 packet receiver.
//   - Data ID codes for the short packets (FS/FE/LS/LE) and the RAW8/RAW10 long packets
//   - Fixed ECC/checksum values emitted by the team serializer
//   - Receiver FSM state type
//   - csi2_ecc: 6-bit Hamming ECC over the 24-bit packet header {WC_H, WC_L, DI}
//   - csi2_crc16_byte: one byte step of CRC-16-CCITT, reflected form (poly 0x8408)
package mipi_csi2_des_pkg;

  localparam logic [7:0] DI_FS    = 8'h00;
  localparam logic [7:0] DI_FE    = 8'h01;
  localparam logic [7:0] DI_LS    = 8'h02;
  localparam logic [7:0] DI_LE    = 8'h03;
  localparam logic [7:0] DI_RAW8  = 8'h2A;
  localparam logic [7:0] DI_RAW10 = 8'h2B;

  localparam logic [7:0]  ECC_FIXED = 8'hEC;
  localparam logic [15:0] CRC_FIXED = 16'hABCD;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_SKIP    = 3'd4
  } csi2_state_t;

  // Parity masks: bit n of ECC_Mk is set when header bit n feeds parity bit k.
  localparam logic [23:0] ECC_M0 = 24'hF12CB7;
  localparam logic [23:0] ECC_M1 = 24'hF2555B;
  localparam logic [23:0] ECC_M2 = 24'h749A6D;
  localparam logic [23:0] ECC_M3 = 24'hB8E38E;
  localparam logic [23:0] ECC_M4 = 24'hDF03F0;
  localparam logic [23:0] ECC_M5 = 24'hEFFC00;

  function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
    return {2'b00, ^(d & ECC_M5), ^(d & ECC_M4), ^(d & ECC_M3),
            ^(d & ECC_M2), ^(d & ECC_M1), ^(d & ECC_M0)};
  endfunction

  function automatic logic [15:0] csi2_crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mipi_csi2_des_raw10_unpack.sv
// RAW10 unpacker: collects 5-byte groups (4 MSB bytes + 1 LSB byte) and
// emits the 4 reassembled 10-bit pixels on the 4 cycles after the group completes.
// Ports:
//   clk_hs        byte clock
//   i_clr         synchronous clear (reset, disable, truncation); drops partial group and shadow
//   i_byte_valid  i_byte is a RAW10 payload byte this cycle
//   i_byte        payload byte
//   i_line_last   this byte is the final payload byte of the line
//   o_pix_valid   a pixel is presented this cycle
//   o_pix_data    pixel value {MSB byte, 2 LSBs}
//   o_pix_last    presented pixel is the last one of the line
//   o_partial     final byte arrived mid-group; that partial group is discarded
module mipi_csi2_des_raw10_unpack (
  input  logic       clk_hs,
  input  logic       i_clr,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte,
  input  logic       i_line_last,
  output logic       o_pix_valid,
  output logic [9:0] o_pix_data,
  output logic       o_pix_last,
  output logic       o_partial
);

  logic [2:0]       r_idx;
  logic [3:0][7:0]  r_msb;
  logic [3:0][9:0]  r_shadow;
  logic [2:0]       r_emit_cnt;
  logic             r_shadow_last;
  logic [1:0]       w_emit_idx;

  // Pixels remaining counts 4..1, so the pixel index is 4 - remaining.
  assign w_emit_idx  = 2'(3'd4 - r_emit_cnt);
  assign o_pix_valid = (r_emit_cnt != 3'd0);
  assign o_pix_data  = r_shadow[w_emit_idx];
  assign o_pix_last  = r_shadow_last && (r_emit_cnt == 3'd1);
  assign o_partial   = i_byte_valid && i_line_last && (r_idx != 3'd4);

  // A new group needs 5 bytes while the shadow drains in 4 cycles, so a load
  // never collides with pixels still waiting to be emitted.
  always_ff @(posedge clk_hs) begin
    if (i_clr) begin
      r_idx         <= 3'd0;
      r_msb         <= '0;
      r_shadow      <= '0;
      r_emit_cnt    <= 3'd0;
      r_shadow_last <= 1'b0;
    end else if (i_byte_valid && (r_idx == 3'd4)) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= {r_msb[i], i_byte[2*i +: 2]};
      end
      r_emit_cnt    <= 3'd4;
      r_shadow_last <= i_line_last;
      r_idx         <= 3'd0;
    end else begin
      if (r_emit_cnt != 3'd0) r_emit_cnt <= r_emit_cnt - 3'd1;
      if (i_byte_valid) begin
        r_msb[r_idx[1:0]] <= i_byte;
        r_idx             <= i_line_last ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/mipi_csi2_des.sv
// CSI-2 packet receiver / depacketizer for one D-PHY lane byte stream.
// Parses short (FS/FE/LS/LE) and long packets, checks header ECC and payload
// checksum, unpacks RAW8/RAW10 pixels and regenerates vsync/href/line_end.
// Ports:
//   clk_hs, reset        byte clock; synchronous active-high reset
//   enable               0 holds everything at reset values
//   rx_active/rx_valid   lane handshake: rx_active is high for the whole HS burst and its
//                        fall marks EoT; rx_data is consumed on every cycle where
//                        rx_active && rx_valid; rx_valid gaps simply stall parsing
//   rx_data              lane byte, first byte of a burst is the data ID
//   pixel_width          8 or 10, must agree with the RAW data type
//   data/dvalid          pixel output (RAW8 zero-extended)
//   vsync/href/line_end  frame/line timing
//   frame_num/line_wc    WC of last FS / last long packet header
//   *_err                1-cycle error pulses
//   dbg_state            current parser state
module mipi_csi2_des
  import mipi_csi2_des_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int CHECK_MODE = 0
) (
  input  logic                  clk_hs,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rx_active,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [3:0]            pixel_width,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  dvalid,
  output logic                  vsync,
  output logic                  href,
  output logic                  line_end,
  output logic [15:0]           frame_num,
  output logic [15:0]           line_wc,
  output logic                  ecc_err,
  output logic                  crc_err,
  output logic                  dtype_err,
  output logic                  trunc_err,
  output csi2_state_t           dbg_state
);

  csi2_state_t r_state, w_next;
  logic [1:0]  r_hdr_cnt;
  logic [7:0]  r_di, r_wc_l, r_wc_h, r_crc_lo;
  logic [15:0] r_wc_cnt, r_crc;
  logic        r_is_raw8, r_crc_phase, r_dlast, r_partial;

  logic        w_clr, w_byte, w_hdr_done, w_ecc_ok, w_width_ok, w_crc_ok;
  logic        w_pay_byte, w_line_last, w_trunc, w_ecc_err, w_dtype_hdr, w_crc_err;
  logic [15:0] w_wc;
  logic        w_u_valid, w_u_last, w_u_partial, w_pix_ok, w_pix_last;
  logic [9:0]  w_u_data, w_pix;

  assign w_clr       = reset || !enable;
  assign w_byte      = rx_active && rx_valid;
  assign w_wc        = {r_wc_h, r_wc_l};
  assign w_hdr_done  = (r_state == ST_HDR) && w_byte && (r_hdr_cnt == 2'd3);
  assign w_ecc_ok    = (CHECK_MODE == 0) ? (rx_data == ECC_FIXED)
                                         : (rx_data == csi2_ecc({r_wc_h, r_wc_l, r_di}));
  assign w_width_ok  = ((r_di == DI_RAW8)  && (pixel_width == 4'd8)) ||
                       ((r_di == DI_RAW10) && (pixel_width == 4'd10));
  // The serializer sends its fixed checksum as bytes AB then CD; the real CRC is LSB first.
  assign w_crc_ok    = (CHECK_MODE == 0) ? ({r_crc_lo, rx_data} == CRC_FIXED)
                                         : ({rx_data, r_crc_lo} == r_crc);
  assign w_pay_byte  = (r_state == ST_PAYLOAD) && w_byte;
  assign w_line_last = (r_wc_cnt == 16'd1);
  assign dbg_state   = r_state;

  always_ff @(posedge clk_hs) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_trunc     = 1'b0;
    w_ecc_err   = 1'b0;
    w_dtype_hdr = 1'b0;
    w_crc_err   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_byte) w_next = ST_HDR;
      ST_HDR: begin
        if (!rx_active) begin
          w_trunc = 1'b1;
          w_next  = ST_IDLE;
        end else if (rx_valid && (r_hdr_cnt == 2'd3)) begin
          w_next = ST_SKIP;
          if (!w_ecc_ok) begin
            w_ecc_err = 1'b1;
          end else if ((r_di == DI_LS) || (r_di == DI_LE)) begin
            w_next = ST_SKIP;
          end else if (((r_di == DI_RAW8) || (r_di == DI_RAW10)) && (w_wc != 16'd0)) begin
            if (w_width_ok) w_next = ST_PAYLOAD;
            else            w_dtype_hdr = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!rx_active) begin
          w_trunc = 1'b1;
          w_next  = ST_IDLE;
        end else if (rx_valid && w_line_last) begin
          w_next = ST_CRC;
        end
      end
      ST_CRC: begin
        if (!rx_active) begin
          w_trunc = 1'b1;
          w_next  = ST_IDLE;
        end else if (rx_valid && r_crc_phase) begin
          w_crc_err = !w_crc_ok;
          w_next    = ST_SKIP;
        end
      end
      ST_SKIP: if (!rx_active) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  mipi_csi2_des_raw10_unpack u_unpack (
    .clk_hs       (clk_hs),
    .i_clr        (w_clr || w_trunc),
    .i_byte_valid (w_pay_byte && !r_is_raw8),
    .i_byte       (rx_data),
    .i_line_last  (w_line_last),
    .o_pix_valid  (w_u_valid),
    .o_pix_data   (w_u_data),
    .o_pix_last   (w_u_last),
    .o_partial    (w_u_partial)
  );

  assign w_pix      = r_is_raw8 ? {2'b00, rx_data} : w_u_data;
  assign w_pix_ok   = !w_trunc && (r_is_raw8 ? w_pay_byte : w_u_valid);
  assign w_pix_last = r_is_raw8 ? w_line_last : w_u_last;

  always_ff @(posedge clk_hs) begin
    if (w_clr) begin
      r_hdr_cnt   <= 2'd0;
      r_di        <= 8'h00;
      r_wc_l      <= 8'h00;
      r_wc_h      <= 8'h00;
      r_wc_cnt    <= 16'd0;
      r_is_raw8   <= 1'b0;
      r_crc       <= 16'hFFFF;
      r_crc_lo    <= 8'h00;
      r_crc_phase <= 1'b0;
      r_dlast     <= 1'b0;
      r_partial   <= 1'b0;
      data        <= '0;
      dvalid      <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      line_end    <= 1'b0;
      frame_num   <= 16'd0;
      line_wc     <= 16'd0;
      ecc_err     <= 1'b0;
      crc_err     <= 1'b0;
      dtype_err   <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_byte) begin
        r_di      <= rx_data;
        r_hdr_cnt <= 2'd1;
      end
      if ((r_state == ST_HDR) && w_byte) begin
        if (r_hdr_cnt == 2'd1) r_wc_l <= rx_data;
        if (r_hdr_cnt == 2'd2) r_wc_h <= rx_data;
        r_hdr_cnt <= r_hdr_cnt + 2'd1;
      end
      if (w_hdr_done && w_ecc_ok) begin
        if (r_di == DI_FS) begin
          vsync     <= 1'b1;
          frame_num <= w_wc;
        end
        if (r_di == DI_FE) vsync <= 1'b0;
        if (r_di[5:0] >= 6'h10) line_wc <= w_wc;
        r_wc_cnt    <= w_wc;
        r_is_raw8   <= (r_di == DI_RAW8);
        r_crc       <= 16'hFFFF;
        r_crc_phase <= 1'b0;
      end
      if (w_pay_byte) begin
        r_wc_cnt <= r_wc_cnt - 16'd1;
        r_crc    <= csi2_crc16_byte(r_crc, rx_data);
      end
      if ((r_state == ST_CRC) && w_byte) begin
        r_crc_lo    <= rx_data;
        r_crc_phase <= ~r_crc_phase;
      end

      dvalid <= w_pix_ok;
      if (w_pix_ok) data <= DATA_WIDTH'(w_pix);
      r_dlast  <= w_pix_ok && w_pix_last;
      line_end <= dvalid && r_dlast && !w_trunc;

      // href drops with line_end, on truncation, or once a line that ended in a
      // discarded partial group has drained its last complete group.
      if (w_trunc)                           href <= 1'b0;
      else if (w_pix_ok)                     href <= 1'b1;
      else if ((dvalid && r_dlast) || r_partial) href <= 1'b0;

      if (w_trunc)                      r_partial <= 1'b0;
      else if (w_u_partial)             r_partial <= 1'b1;
      else if (r_partial && !w_pix_ok)  r_partial <= 1'b0;

      ecc_err   <= w_ecc_err;
      crc_err   <= w_crc_err;
      dtype_err <= w_dtype_hdr || w_u_partial;
      trunc_err <= w_trunc;
    end
  end

endmodule

// File: tb/tb_mipi_csi2_des.sv
// Directed bench for mipi_csi2_des: packets are driven byte by byte, expected
// pixels go into exp_q and a negedge monitor pops/compares every dvalid.
module tb_mipi_csi2_des;
  import mipi_csi2_des_pkg::*;

  // clock / reset
  logic clk_hs = 1'b0;
  always #5 clk_hs = ~clk_hs;

  logic        reset, enable, rx_active, rx_valid;
  logic [7:0]  rx_data;
  logic [3:0]  pixel_width;
  logic [9:0]  data;
  logic        dvalid, vsync, href, line_end;
  logic [15:0] frame_num, line_wc;
  logic        ecc_err, crc_err, dtype_err, trunc_err;
  csi2_state_t dbg_state;

  mipi_csi2_des #(.DATA_WIDTH(10), .CHECK_MODE(0)) dut (
    .clk_hs(clk_hs), .reset(reset), .enable(enable), .rx_active(rx_active),
    .rx_valid(rx_valid), .rx_data(rx_data), .pixel_width(pixel_width),
    .data(data), .dvalid(dvalid), .vsync(vsync), .href(href), .line_end(line_end),
    .frame_num(frame_num), .line_wc(line_wc), .ecc_err(ecc_err), .crc_err(crc_err),
    .dtype_err(dtype_err), .trunc_err(trunc_err), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];
  logic [7:0] pkt[$];
  int cnt_le, cnt_ecc, cnt_crc, cnt_dt, cnt_tr, cnt_dv;
  int cyc = 0;
  int first_dv, last_dv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_le = 0; cnt_ecc = 0; cnt_crc = 0; cnt_dt = 0; cnt_tr = 0; cnt_dv = 0;
    first_dv = 0; last_dv = 0;
  endtask

  // driver tasks
  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk_hs);
    rx_active = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = b;
  endtask

  task automatic send_pkt(input bit gaps);
    foreach (pkt[i]) begin
      drive_byte(pkt[i]);
      if (gaps) begin
        @(negedge clk_hs);
        rx_valid = 1'b0;
      end
    end
    @(negedge clk_hs);
    rx_valid = 1'b0;
    @(negedge clk_hs);
    rx_active = 1'b0;
    repeat (10) @(negedge clk_hs);
  endtask

  // scoreboard monitor
  always @(negedge clk_hs) begin
    cyc++;
    if (!reset) begin
      if (dvalid) begin
        if (cnt_dv == 0) first_dv = cyc;
        last_dv = cyc;
        cnt_dv++;
        check("href_during_dvalid", {31'd0, href}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pixel: got unexpected 0x%0h expected none", data);
        end else begin
          check("pixel", {22'd0, data}, {22'd0, exp_q.pop_front()});
        end
      end
      if (line_end)  cnt_le++;
      if (ecc_err)   cnt_ecc++;
      if (crc_err)   cnt_crc++;
      if (dtype_err) cnt_dt++;
      if (trunc_err) cnt_tr++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; rx_active = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; pixel_width = 4'd8;
    clear_counts();
    repeat (3) @(negedge clk_hs);
    check("rst_vsync", {31'd0, vsync}, 32'd0);
    check("rst_dvalid", {31'd0, dvalid}, 32'd0);
    check("rst_frame_num", {16'd0, frame_num}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    reset = 1'b0;
    repeat (2) @(negedge clk_hs);

    // 1: FS / FE
    pkt = '{8'h00, 8'h05, 8'h00, 8'hEC};
    send_pkt(1'b0);
    check("fs_vsync", {31'd0, vsync}, 32'd1);
    check("fs_frame_num", {16'd0, frame_num}, 32'd5);
    pkt = '{8'h01, 8'h00, 8'h00, 8'hEC};
    send_pkt(1'b0);
    check("fe_vsync", {31'd0, vsync}, 32'd0);
    check("fsfe_no_dvalid", cnt_dv, 32'd0);
    check("fsfe_no_errors", cnt_ecc + cnt_crc + cnt_dt + cnt_tr, 32'd0);

    // 2: RAW8 line, good then bad checksum
    pkt = '{8'h00, 8'h01, 8'h00, 8'hEC};
    send_pkt(1'b0);
    clear_counts();
    exp_q.push_back(10'h011); exp_q.push_back(10'h022);
    exp_q.push_back(10'h033); exp_q.push_back(10'h044);
    pkt = '{8'h2A, 8'h04, 8'h00, 8'hEC, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 8'hCD};
    send_pkt(1'b0);
    check("raw8_line_end", cnt_le, 32'd1);
    check("raw8_no_crc_err", cnt_crc, 32'd0);
    check("raw8_line_wc", {16'd0, line_wc}, 32'd4);
    check("raw8_href_low", {31'd0, href}, 32'd0);
    clear_counts();
    exp_q.push_back(10'h055);
    pkt = '{8'h2A, 8'h01, 8'h00, 8'hEC, 8'h55, 8'h00, 8'h00};
    send_pkt(1'b1);
    check("badcrc_line_end", cnt_le, 32'd1);
    check("badcrc_crc_err", cnt_crc, 32'd1);

    // 3: RAW10 group, wrong width, partial group
    pixel_width = 4'd10;
    clear_counts();
    exp_q.push_back(10'h203); exp_q.push_back(10'h102);
    exp_q.push_back(10'h301); exp_q.push_back(10'h3FC);
    pkt = '{8'h2B, 8'h05, 8'h00, 8'hEC, 8'h80, 8'h40, 8'hC0, 8'hFF, 8'h1B, 8'hAB, 8'hCD};
    send_pkt(1'b0);
    check("raw10_count", cnt_dv, 32'd4);
    check("raw10_consecutive", last_dv - first_dv, 32'd3);
    check("raw10_line_end", cnt_le, 32'd1);
    check("raw10_no_err", cnt_crc + cnt_dt, 32'd0);
    pixel_width = 4'd8;
    clear_counts();
    pkt = '{8'h2B, 8'h05, 8'h00, 8'hEC, 8'h80, 8'h40, 8'hC0, 8'hFF, 8'h1B, 8'hAB, 8'hCD};
    send_pkt(1'b0);
    check("width_dtype_err", cnt_dt, 32'd1);
    check("width_no_dvalid", cnt_dv, 32'd0);
    pixel_width = 4'd10;
    clear_counts();
    exp_q.push_back(10'h203); exp_q.push_back(10'h102);
    exp_q.push_back(10'h301); exp_q.push_back(10'h3FC);
    pkt = '{8'h2B, 8'h07, 8'h00, 8'hEC, 8'h80, 8'h40, 8'hC0, 8'hFF, 8'h1B,
            8'h55, 8'h66, 8'hAB, 8'hCD};
    send_pkt(1'b0);
    check("partial_dtype_err", cnt_dt, 32'd1);
    check("partial_no_line_end", cnt_le, 32'd0);
    check("partial_href_low", {31'd0, href}, 32'd0);
    check("partial_line_wc", {16'd0, line_wc}, 32'd7);

    // 4: bad header ECC, then a good FS
    clear_counts();
    pkt = '{8'h00, 8'h07, 8'h00, 8'h00};
    send_pkt(1'b0);
    check("ecc_err_pulse", cnt_ecc, 32'd1);
    check("ecc_frame_kept", {16'd0, frame_num}, 32'd1);
    pkt = '{8'h00, 8'h09, 8'h00, 8'hEC};
    send_pkt(1'b0);
    check("ecc_next_fs", {16'd0, frame_num}, 32'd9);
    check("ecc_single", cnt_ecc, 32'd1);

    // enable low clears state
    @(negedge clk_hs);
    enable = 1'b0;
    @(negedge clk_hs);
    check("dis_vsync", {31'd0, vsync}, 32'd0);
    check("dis_frame_num", {16'd0, frame_num}, 32'd0);
    enable = 1'b1;
    repeat (2) @(negedge clk_hs);

    // 5: truncated RAW8 line
    pixel_width = 4'd8;
    clear_counts();
    exp_q.push_back(10'h001); exp_q.push_back(10'h002); exp_q.push_back(10'h003);
    pkt = '{8'h2A, 8'h08, 8'h00, 8'hEC, 8'h01, 8'h02, 8'h03};
    send_pkt(1'b0);
    check("trunc_pixels", cnt_dv, 32'd3);
    check("trunc_err_pulse", cnt_tr, 32'd1);
    check("trunc_no_line_end", cnt_le, 32'd0);
    check("trunc_href_low", {31'd0, href}, 32'd0);

    // 6: reset in the middle of a RAW10 group, then a clean line with gaps
    pixel_width = 4'd10;
    pkt = '{8'h00, 8'h03, 8'h00, 8'hEC};
    send_pkt(1'b0);
    clear_counts();
    drive_byte(8'h2B); drive_byte(8'h05); drive_byte(8'h00); drive_byte(8'hEC);
    drive_byte(8'h80); drive_byte(8'h40);
    @(negedge clk_hs);
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_active = 1'b0;
    @(negedge clk_hs);
    check("midrst_vsync", {31'd0, vsync}, 32'd0);
    check("midrst_href", {31'd0, href}, 32'd0);
    check("midrst_line_wc", {16'd0, line_wc}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    reset = 1'b0;
    repeat (3) @(negedge clk_hs);
    clear_counts();
    exp_q.push_back(10'h000); exp_q.push_back(10'h3FD);
    exp_q.push_back(10'h04A); exp_q.push_back(10'h0D3);
    pkt = '{8'h2B, 8'h05, 8'h00, 8'hEC, 8'h00, 8'hFF, 8'h12, 8'h34, 8'hE4, 8'hAB, 8'hCD};
    send_pkt(1'b1);
    check("clean_count", cnt_dv, 32'd4);
    check("clean_line_end", cnt_le, 32'd1);
    check("clean_no_err", cnt_ecc + cnt_crc + cnt_dt + cnt_tr, 32'd0);

    // final report
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
